// File: rtl/psram_bridge_pkg.sv
// Shared types and constants for the CPU6 byte bus to PsramController word bridge.
package psram_bridge_pkg;

    localparam int ADDR_W     = 22;
    localparam int CPU_ADDR_W = 19;
    localparam logic [7:0] READ_ERR_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PEND    = 3'd1,
        ST_STROBE  = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/psram_bridge_rdbuf.sv
// One-word read buffer (data, word tag, valid) with write-byte merge; hit is combinational.
// Only built when PSRAM_BRIDGE_RDBUF_EN is defined.
module psram_bridge_rdbuf
    import psram_bridge_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [ADDR_W-2:0]   lookup_tag_i,
    output logic                hit_o,
    output logic [15:0]         buf_dat_o,
    input  logic                fill_vld_i,
    input  logic [ADDR_W-2:0]   fill_tag_i,
    input  logic [15:0]         fill_dat_i,
    input  logic                merge_vld_i,
    input  logic                merge_hi_i,
    input  logic [7:0]          merge_dat_i,
    input  logic                inval_i
);

    logic [15:0]       dat_q;
    logic [ADDR_W-2:0] tag_q;
    logic              valid_q;

    assign hit_o     = valid_q && (tag_q == lookup_tag_i);
    assign buf_dat_o = dat_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dat_q   <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end else if (fill_vld_i) begin
            dat_q   <= fill_dat_i;
            tag_q   <= fill_tag_i;
            valid_q <= 1'b1;
        end else if (merge_vld_i && hit_o) begin
            // Keep the buffered word coherent with the PSRAM write that follows.
            if (merge_hi_i) dat_q[15:8] <= merge_dat_i;
            else            dat_q[7:0]  <= merge_dat_i;
        end
    end

endmodule

// File: rtl/psram_bus_bridge.sv
// CPU6 byte bus to PsramController bridge: strobe at req+1, done 1 cycle after busy falls, timeout -> err.
// cpu_busy holds from acceptance to cpu_done; requests while busy are dropped. PSRAM_BRIDGE_RDBUF_EN adds a read buffer.
module psram_bus_bridge
    import psram_bridge_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE      = 22'h000000,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter int                TO_W           = 11
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [CPU_ADDR_W-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_busy,
    output logic                  cpu_done,
    output logic                  cpu_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_byte_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [15:0]           mem_din,
    input  logic [15:0]           mem_dout,
    input  logic                  mem_busy
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                lsb_q, lsb_d;
    logic                err_q, err_d;
    logic [7:0]          rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_din_q, mem_din_d;
    logic                mem_bw_q, mem_bw_d;

    logic [ADDR_W-1:0]   req_addr;
    logic                timeout_ev;
    logic                strobe_ok;
    logic                hit_q;
    logic                buf_hit;
    logic [15:0]         buf_dat;

    assign req_addr   = ADDR_BASE + {{(ADDR_W-CPU_ADDR_W){1'b0}}, cpu_addr};
    assign timeout_ev = (cnt_q == TO_LAST) &&
                        (((state_q == ST_WAIT_HI) && !mem_busy) ||
                         ((state_q == ST_WAIT_LO) &&  mem_busy));
    // Gating on mem_busy keeps the strobe off a busy controller; STROBE simply waits.
    assign strobe_ok  = (state_q == ST_STROBE) && !hit_q && !mem_busy;

    assign mem_read       = strobe_ok && !we_q;
    assign mem_write      = strobe_ok &&  we_q;
    assign cpu_busy       = (state_q != ST_IDLE);
    assign cpu_done       = (state_q == ST_DONE);
    assign cpu_err        = cpu_done && err_q;
    assign cpu_rdata      = rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;
    assign mem_byte_write = mem_bw_q;

`ifdef PSRAM_BRIDGE_RDBUF_EN
    logic hit_d;

    // A buffer hit travels through STROBE with no strobe so done lands 2 cycles after req.
    assign hit_d = (state_q == ST_IDLE) ? (cpu_req && !cpu_we && buf_hit) :
                   (state_q == ST_DONE) ? 1'b0 : hit_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) hit_q <= 1'b0;
        else         hit_q <= hit_d;
    end

    psram_bridge_rdbuf u_rdbuf (
        .clk          (clk),
        .resetn       (resetn),
        .lookup_tag_i (req_addr[ADDR_W-1:1]),
        .hit_o        (buf_hit),
        .buf_dat_o    (buf_dat),
        .fill_vld_i   ((state_q == ST_WAIT_LO) && !mem_busy && !we_q),
        .fill_tag_i   (mem_addr_q[ADDR_W-1:1]),
        .fill_dat_i   (mem_dout),
        .merge_vld_i  ((state_q == ST_IDLE) && cpu_req && cpu_we),
        .merge_hi_i   (cpu_addr[0]),
        .merge_dat_i  (cpu_wdata),
        .inval_i      (timeout_ev)
    );
`else
    assign hit_q   = 1'b0;
    assign buf_hit = 1'b0;
    assign buf_dat = '0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        lsb_d      = lsb_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_bw_d   = mem_bw_q;

        unique case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (cpu_req) begin
                    we_d       = cpu_we;
                    lsb_d      = cpu_addr[0];
                    mem_addr_d = req_addr;
                    mem_din_d  = {cpu_wdata, cpu_wdata};
                    mem_bw_d   = cpu_we;
                    state_d    = ((!cpu_we && buf_hit) || !mem_busy) ? ST_STROBE : ST_PEND;
                end
            end
            ST_PEND: begin
                if (!mem_busy) state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (hit_q) begin
                    rdata_d = lsb_q ? buf_dat[15:8] : buf_dat[7:0];
                    state_d = ST_DONE;
                end else if (!mem_busy) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (mem_busy) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LO;
                end else begin
                    cnt_d = cnt_q + TO_ONE;
                end
            end
            ST_WAIT_LO: begin
                if (!mem_busy) begin
                    if (!we_q) rdata_d = lsb_q ? mem_dout[15:8] : mem_dout[7:0];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + TO_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeout_ev) begin
            err_d   = 1'b1;
            if (!we_q) rdata_d = READ_ERR_BYTE;
            state_d = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            lsb_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 8'h00;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_bw_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            lsb_q      <= lsb_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_bw_q   <= mem_bw_d;
        end
    end

endmodule

// File: tb/tb_psram_bus_bridge.sv
// Directed bench for psram_bus_bridge with a cycle-stepped PsramController model.
module tb_psram_bus_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_err;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte_write;
    logic [21:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    int          r_strobes, r_strobe_cyc, r_req_cyc, r_done_cyc, r_busy_low_cyc, r_drop_cyc;
    bit          r_done_seen, r_err, r_bw, r_busy_acc;
    bit          r_bad = 1'b0;
    logic [7:0]  r_rd;
    logic [21:0] r_addr;
    logic [15:0] r_din;

    psram_bus_bridge #(
        .ADDR_BASE      (22'h100000),
        .TIMEOUT_CYCLES (16),
        .TO_W           (5)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_busy       (cpu_busy),
        .cpu_done       (cpu_done),
        .cpu_err        (cpu_err),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_write (mem_byte_write),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_busy       (mem_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU transaction; the model raises busy the cycle after a strobe, holds it 3 cycles, then drops it.
    task automatic txn(input bit we, input logic [18:0] a, input logic [7:0] wd,
                       input logic [15:0] dout, input bit respond, input int pend, input bit poke);
        int  s_cyc;
        bit  done;
        s_cyc = -1;
        done  = 1'b0;
        r_strobes = 0; r_strobe_cyc = -1; r_done_cyc = -1; r_busy_low_cyc = -1; r_drop_cyc = -1;
        r_done_seen = 1'b0; r_err = 1'b0; r_bw = 1'b0; r_busy_acc = 1'b0;
        r_rd = 8'h00; r_addr = '0; r_din = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        r_req_cyc = cyc;
        for (int i = 1; i <= 400 && !done; i++) begin
            tick();
            cpu_req = 1'b0;
            if (i == 1) r_busy_acc = cpu_busy;
            if (mem_read && mem_write) r_bad = 1'b1;
            if ((mem_read || mem_write) && mem_busy) r_bad = 1'b1;
            if (mem_read || mem_write) begin
                r_strobes++;
                r_strobe_cyc = cyc;
                s_cyc  = cyc;
                r_addr = mem_addr;
                r_din  = mem_din;
                r_bw   = mem_byte_write;
            end
            if (cpu_done) begin
                done        = 1'b1;
                r_done_seen = 1'b1;
                r_done_cyc  = cyc;
                r_err       = cpu_err;
                r_rd        = cpu_rdata;
            end
            if (pend > 0 && i == pend) begin
                mem_busy   = 1'b0;
                r_drop_cyc = cyc;
            end
            if (respond && s_cyc >= 0 && cyc == s_cyc + 1) mem_busy = 1'b1;
            if (respond && s_cyc >= 0 && cyc == s_cyc + 4) begin
                mem_busy       = 1'b0;
                mem_dout       = dout;
                r_busy_low_cyc = cyc;
            end
            if (poke && s_cyc >= 0 && cyc == s_cyc + 2) begin
                cpu_req  = 1'b1;
                cpu_we   = ~we;
                cpu_addr = a ^ 19'h1;
            end
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            cpu_req = 1'b0;
            if (mem_read && mem_write) r_bad = 1'b1;
            if (mem_read || mem_write) r_strobes++;
        end
    endtask

    initial begin
        resetn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_dout = '0; mem_busy = 1'b1;
        repeat (3) tick();
        chk("rst_rdata", cpu_rdata, 8'h00);
        chk("rst_busy_done_err", {cpu_busy, cpu_done, cpu_err}, 3'b000);
        chk("rst_strobes", {mem_read, mem_write}, 2'b00);
        chk("rst_mem_addr", mem_addr, 22'h000000);
        chk("rst_mem_din", mem_din, 16'h0000);
        chk("rst_byte_write", mem_byte_write, 1'b0);

        resetn = 1'b1;
        repeat (10) tick();
        // Controller init: busy stays high for 200 cycles after reset release.
        txn(1'b0, 19'h00010, 8'h00, 16'hBEEF, 1'b1, 190, 1'b0);
        chk("pend_done", r_done_seen, 1'b1);
        chk("pend_strobes", r_strobes, 1);
        chk("pend_strobe_after_drop", r_strobe_cyc - r_drop_cyc, 1);
        chk("pend_addr", r_addr, 22'h100010);
        chk("pend_bw", r_bw, 1'b0);
        chk("pend_rdata", r_rd, 8'hEF);

        txn(1'b1, 19'h00005, 8'hA5, 16'h0000, 1'b1, 0, 1'b0);
        chk("wr_done", r_done_seen, 1'b1);
        chk("wr_busy_after_accept", r_busy_acc, 1'b1);
        chk("wr_strobes", r_strobes, 1);
        chk("wr_strobe_lat", r_strobe_cyc - r_req_cyc, 1);
        chk("wr_addr", r_addr, 22'h100005);
        chk("wr_din", r_din, 16'hA5A5);
        chk("wr_bw", r_bw, 1'b1);
        chk("wr_done_after_busy_low", r_done_cyc - r_busy_low_cyc, 1);
        chk("wr_err", r_err, 1'b0);

        txn(1'b0, 19'h00003, 8'h00, 16'h12C4, 1'b1, 0, 1'b0);
        chk("rd_hi_rdata", r_rd, 8'h12);
        chk("rd_hi_strobes", r_strobes, 1);
        chk("rd_hi_latency", r_done_cyc - r_req_cyc, 6);
        chk("rd_hi_addr", r_addr, 22'h100003);

        txn(1'b0, 19'h00002, 8'h00, 16'h12C4, 1'b1, 0, 1'b0);
        chk("rd_lo_rdata", r_rd, 8'hC4);
`ifdef PSRAM_BRIDGE_RDBUF_EN
        chk("rd_lo_strobes", r_strobes, 0);
`else
        chk("rd_lo_strobes", r_strobes, 1);
`endif

        txn(1'b0, 19'h00040, 8'h00, 16'h0000, 1'b0, 0, 1'b0);
        chk("to_done", r_done_seen, 1'b1);
        chk("to_err", r_err, 1'b1);
        chk("to_rdata", r_rd, 8'hFF);
        chk("to_latency", r_done_cyc - r_req_cyc, 18);
        chk("to_strobes", r_strobes, 1);

        txn(1'b0, 19'h00041, 8'h00, 16'h5A3C, 1'b1, 0, 1'b0);
        chk("after_to_rdata", r_rd, 8'h5A);
        chk("after_to_err", r_err, 1'b0);
        chk("after_to_strobes", r_strobes, 1);

        txn(1'b1, 19'h00008, 8'h3C, 16'h0000, 1'b1, 0, 1'b1);
        chk("poke_done", r_done_seen, 1'b1);
        chk("poke_strobes", r_strobes, 1);

`ifdef PSRAM_BRIDGE_RDBUF_EN
        txn(1'b0, 19'h00020, 8'h00, 16'h9911, 1'b1, 0, 1'b0);
        chk("buf_fill_rdata", r_rd, 8'h11);
        chk("buf_fill_strobes", r_strobes, 1);
        txn(1'b0, 19'h00021, 8'h00, 16'h0000, 1'b1, 0, 1'b0);
        chk("buf_hit_rdata", r_rd, 8'h99);
        chk("buf_hit_strobes", r_strobes, 0);
        chk("buf_hit_latency", r_done_cyc - r_req_cyc, 2);
        txn(1'b1, 19'h00021, 8'h77, 16'h0000, 1'b1, 0, 1'b0);
        chk("buf_wr_strobes", r_strobes, 1);
        txn(1'b0, 19'h00021, 8'h00, 16'h0000, 1'b1, 0, 1'b0);
        chk("buf_merge_rdata", r_rd, 8'h77);
        chk("buf_merge_strobes", r_strobes, 0);
`endif

        chk("strobe_exclusive", r_bad, 1'b0);

        // Reset in the middle of a read aborts with no done pulse.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00060;
        tick();
        cpu_req = 1'b0;
        repeat (2) tick();
        chk("mid_busy_before_rst", cpu_busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy_done", {cpu_busy, cpu_done, cpu_err}, 3'b000);
        tick();
        resetn = 1'b1;
        tick();
        chk("mid_rst_idle", {cpu_busy, cpu_done}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
